// File: rtl/idli_seq.sv
`default_nettype none
// ============================================================================
//  Module      : idli_seq
//  Description : Timeslot sequencer for a nibble-serial core. A 2-bit slice
//                counter divides time into 4-cycle timeslots. A state machine
//                advances only at the slot boundary (ctr==3). It accepts
//                encodings, consumes or skips immediate words, runs execute
//                slots, and tracks a memory phase with an acknowledge timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module idli_seq #(
    parameter int MEM_TO = 8
) (
    input  logic       i_seq_gck,
    input  logic       i_seq_rst,
    output logic [1:0] o_seq_ctr,
    input  logic       i_seq_enc_vld,
    input  logic       i_seq_enc_imm,
    input  logic       i_seq_enc_cond,
    input  logic       i_seq_enc_mem,
    input  logic       i_seq_pred,
    input  logic       i_seq_mem_ack,
    output logic       o_seq_run,
    output logic       o_seq_imm,
    output logic       o_seq_mem,
    output logic       o_seq_fetch,
    output logic       o_seq_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IMM  = 3'd1,
        EXEC = 3'd2,
        MEM  = 3'd3,
        SKIP = 3'd4
    } state_t;

    localparam logic [3:0] TO_LIMIT = 4'(MEM_TO);

    state_t     state;
    state_t     state_nxt;
    state_t     accept_tgt;
    logic [1:0] ctr;
    logic       imm_q;
    logic       mem_q;
    logic       ack_q;
    logic [3:0] to_cnt;
    logic       err;

    logic       boundary;
    logic       accept;
    logic       skip;
    logic       to_clr;
    logic       to_inc;
    logic       err_set;

    // Next state, accept qualification and timeout control; all moves are gated on the boundary.
    always_comb begin
        state_nxt  = state;
        to_clr     = 1'b0;
        to_inc     = 1'b0;
        err_set    = 1'b0;
        boundary   = (ctr == 2'd3);
        accept     = boundary && i_seq_enc_vld &&
                     ((state == IDLE) || ((state == EXEC) && !mem_q));
        skip       = i_seq_enc_cond && !i_seq_pred;
        // A skipped instruction without an immediate is dropped outright.
        if (skip) begin
            accept_tgt = i_seq_enc_imm ? SKIP : IDLE;
        end else begin
            accept_tgt = i_seq_enc_imm ? IMM : EXEC;
        end
        if (boundary) begin
            case (state)
                IDLE: begin
                    if (i_seq_enc_vld) state_nxt = accept_tgt;
                end
                IMM: begin
                    if (i_seq_enc_vld) state_nxt = EXEC;
                end
                SKIP: begin
                    if (i_seq_enc_vld) state_nxt = IDLE;
                end
                EXEC: begin
                    if (mem_q) begin
                        state_nxt = MEM;
                        to_clr    = 1'b1;
                    end else if (i_seq_enc_vld) begin
                        state_nxt = accept_tgt;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                MEM: begin
                    if (ack_q || i_seq_mem_ack) begin
                        state_nxt = IDLE;
                    end else if ((to_cnt + 4'd1) == TO_LIMIT) begin
                        state_nxt = IDLE;
                        err_set   = 1'b1;
                    end else begin
                        to_inc    = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Free-running slice counter; never stalls.
    always_ff @(posedge i_seq_gck or posedge i_seq_rst) begin
        if (i_seq_rst) ctr <= 2'd0;
        else           ctr <= ctr + 2'd1;
    end

    // State register.
    always_ff @(posedge i_seq_gck or posedge i_seq_rst) begin
        if (i_seq_rst) state <= IDLE;
        else           state <= state_nxt;
    end

    // Encoding flags are captured only when an encoding is accepted.
    always_ff @(posedge i_seq_gck or posedge i_seq_rst) begin
        if (i_seq_rst) begin
            imm_q <= 1'b0;
            mem_q <= 1'b0;
        end else if (accept) begin
            imm_q <= i_seq_enc_imm;
            mem_q <= i_seq_enc_mem;
        end
    end

    // Acknowledge catch: held within a MEM slot, dropped at every boundary so it never leaks.
    always_ff @(posedge i_seq_gck or posedge i_seq_rst) begin
        if (i_seq_rst)                          ack_q <= 1'b0;
        else if (boundary)                      ack_q <= 1'b0;
        else if (state == MEM && i_seq_mem_ack) ack_q <= 1'b1;
    end

    // Memory-phase timeout counter.
    always_ff @(posedge i_seq_gck or posedge i_seq_rst) begin
        if (i_seq_rst)   to_cnt <= 4'd0;
        else if (to_clr) to_cnt <= 4'd0;
        else if (to_inc) to_cnt <= to_cnt + 4'd1;
    end

    // Sticky timeout error; only reset clears it.
    always_ff @(posedge i_seq_gck or posedge i_seq_rst) begin
        if (i_seq_rst)    err <= 1'b0;
        else if (err_set) err <= 1'b1;
    end

    assign o_seq_ctr   = ctr;
    assign o_seq_run   = (state == EXEC);
    // IMM and SKIP are only reachable through an accept with the imm flag set.
    assign o_seq_imm   = ((state == IMM) || (state == SKIP)) && imm_q;
    assign o_seq_mem   = (state == MEM);
    assign o_seq_fetch = (state == IDLE) || (state == IMM) || (state == SKIP) ||
                         ((state == EXEC) && !mem_q);
    assign o_seq_err   = err;

endmodule
`default_nettype wire
